// File: rtl/actmem_pkg.sv
// Shared types and width helpers for the activation-memory write path.
// Trits are packed 5 per byte as a base-3 number, trit position 0 least significant.
package actmem_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_POS  = 2'b01;
  localparam trit_t TRIT_NEG  = 2'b11;

  localparam int TRITS_PER_BYTE = 5;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  function automatic int phys_trits(input int eff);
    return ((eff + TRITS_PER_BYTE - 1) / TRITS_PER_BYTE) * TRITS_PER_BYTE;
  endfunction

  function automatic int phys_bits(input int eff);
    return phys_trits(eff) / TRITS_PER_BYTE * 8;
  endfunction

  function automatic int num_encoders(input int eff);
    return phys_trits(eff) / TRITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/activationmemory_writepacker_encoder.sv
// Packs 5 trits into one byte: byte = sum(d_i * 3^i), digit d = 0/1/2 for trit 0/+1/-1.
// Input 2'b10 never reaches here; it is sanitised upstream.
module activationmemory_writepacker_encoder
  import actmem_pkg::*;
(
  input  trit_t [TRITS_PER_BYTE-1:0] trits_i,
  output logic  [7:0]                byte_o
);

  function automatic logic [7:0] digit(input trit_t t);
    case (t)
      TRIT_POS: return 8'd1;
      TRIT_NEG: return 8'd2;
      default:  return 8'd0;
    endcase
  endfunction

  // Horner evaluation from the most significant position down.
  always_comb begin
    byte_o = '0;
    for (int i = TRITS_PER_BYTE - 1; i >= 0; i--) begin
      byte_o = byte_o * 8'd3 + digit(trits_i[i]);
    end
  end

endmodule

// File: rtl/activationmemory_writepacker.sv
// Collects ternary activation beats into one bank word, encodes it and writes it
// to consecutive bank addresses, deferring each write while the bank is being read.
module activationmemory_writepacker
  import actmem_pkg::*;
#(
  parameter  int N_I            = 512,
  parameter  int WEIGHT_STAGGER = 8,
  parameter  int BANKDEPTH      = 1024,
  parameter  int TRITSPERBEAT   = 16,
  localparam int EFF_TRITS      = N_I / WEIGHT_STAGGER,
  localparam int PHYS_TRITS     = phys_trits(EFF_TRITS),
  localparam int PHYS_BITS      = phys_bits(EFF_TRITS),
  localparam int NUM_ENC        = num_encoders(EFF_TRITS),
  localparam int BEATS          = EFF_TRITS / TRITSPERBEAT,
  localparam int AW             = $clog2(BANKDEPTH),
  localparam int BW             = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [AW-1:0]              base_addr_i,
  input  logic [AW:0]                num_words_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  trit_t [TRITSPERBEAT-1:0]   in_trits_i,
  input  logic                       read_active_i,
  output logic                       write_enable_o,
  output logic [AW-1:0]              addr_o,
  output logic [PHYS_BITS-1:0]       wdata_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       illegal_trit_o
);

  state_e                     state_q, state_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [AW:0]                rem_q, rem_d;
  trit_t [EFF_TRITS-1:0]      buf_q, buf_d;
  logic [PHYS_BITS-1:0]       wdata_q, wdata_d, enc_word;
  logic                       done_q, done_d;
  logic                       ill_q, ill_d;

  trit_t [TRITSPERBEAT-1:0]   beat_clean;
  logic  [TRITSPERBEAT-1:0]   lane_ill;
  trit_t [PHYS_TRITS-1:0]     phys;
  logic                       hs, last_beat;

  // Illegal code 2'b10 is stored as zero and only reported through the sticky flag.
  for (genvar l = 0; l < TRITSPERBEAT; l++) begin : g_lane
    assign lane_ill[l]   = (in_trits_i[l] == 2'b10);
    assign beat_clean[l] = lane_ill[l] ? TRIT_ZERO : in_trits_i[l];
  end

  assign hs        = in_valid_i && (state_q == FILL);
  assign last_beat = (beat_q == BW'(BEATS - 1));

  always_comb begin
    buf_d = buf_q;
    if (hs) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_q == BW'(b)) buf_d[b*TRITSPERBEAT +: TRITSPERBEAT] = beat_clean;
      end
    end
  end

  // Encoders see the buffer including the beat arriving this cycle, so the
  // word can be registered on the final handshake.
  always_comb begin
    phys = '0;
    phys[EFF_TRITS-1:0] = buf_d;
  end

  for (genvar n = 0; n < NUM_ENC; n++) begin : g_enc
    activationmemory_writepacker_encoder u_enc (
      .trits_i (phys[n*TRITS_PER_BYTE +: TRITS_PER_BYTE]),
      .byte_o  (enc_word[n*8 +: 8])
    );
  end

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    addr_d         = addr_q;
    rem_d          = rem_q;
    wdata_d        = wdata_q;
    ill_d          = ill_q;
    done_d         = 1'b0;
    in_ready_o     = 1'b0;
    write_enable_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d = base_addr_i;
          rem_d  = num_words_i;
          beat_d = '0;
          ill_d  = 1'b0;
          if (num_words_i == '0) done_d  = 1'b1;
          else                   state_d = FILL;
        end
      end
      FILL: begin
        in_ready_o = 1'b1;
        if (hs) begin
          ill_d = ill_q | (|lane_ill);
          if (last_beat) begin
            wdata_d = enc_word;
            beat_d  = '0;
            state_d = WRITE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WRITE: begin
        write_enable_o = ~read_active_i;
        if (!read_active_i) begin
          addr_d = (addr_q == AW'(BANKDEPTH - 1)) ? '0 : addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (AW+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  assign addr_o         = addr_q;
  assign wdata_o        = wdata_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign illegal_trit_o = ill_q;

endmodule
